// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller for RV32 loads/stores.
// Word-crossing accesses are split into two beats; out-of-range or illegal accesses fault.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        store,
  input  logic [31:0] direccion,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [2:0]  Type,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {INIT, IDLE, BEAT2} state_t;
  state_t state_reg, state_next;

  logic [AW-1:0] init_idx_reg;
  logic          is_store_reg;
  logic [2:0]    type_reg;
  logic [1:0]    byte_off_reg;
  logic [AW-1:0] hi_idx_reg;
  logic [31:0]   hi_data_reg;
  logic [3:0]    hi_be_reg;
  logic [31:0]   lo_word_reg;
  logic          done_reg, fault_reg;
  logic [31:0]   load_data_reg;

  logic [31:0]   addr;
  logic [1:0]    byte_off;
  logic [AW-1:0] acc_idx;
  logic [2:0]    size;
  logic          illegal, oob, misaligned, acc_fault, accept, beat2;
  logic [32:0]   last_byte;
  logic [3:0]    base_be;
  logic [7:0]    be_wide;
  logic [63:0]   data_wide;

  assign addr     = direccion + offset;
  assign byte_off = addr[1:0];
  assign acc_idx  = addr[AW+1:2];
  assign beat2    = (state_reg == BEAT2);

  always_comb begin
    illegal = 1'b0;
    size    = 3'd1;
    if (store) begin
      case (Type)
        3'd0:    size = 3'd1;
        3'd1:    size = 3'd2;
        3'd2:    size = 3'd4;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (Type)
        3'd0, 3'd3: size = 3'd1;
        3'd1, 3'd4: size = 3'd2;
        3'd2:       size = 3'd4;
        default:    illegal = 1'b1;
      endcase
    end
  end

  // Range check on the last byte in 33 bits so a high address cannot wrap back in range.
  assign last_byte  = {1'b0, addr} + {30'd0, size} - 33'd1;
  assign oob        = (last_byte >= LIMIT);
  assign misaligned = ({2'b00, byte_off} + {1'b0, size}) > 4'd4;
  assign acc_fault  = illegal | oob;
  assign accept     = ready & req;
  assign base_be    = (size == 3'd4) ? 4'b1111 : (size == 3'd2) ? 4'b0011 : 4'b0001;
  assign be_wide    = {4'b0000, base_be} << byte_off;
  assign data_wide  = {32'd0, store_data} << {byte_off, 3'b000};

  // Single shared write port: INIT clear, acceptance-edge write, or BEAT2 high half.
  logic          wr_en;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_data, rd_word;
  logic [3:0]    wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_data = data_wide[31:0];
    wr_be   = be_wide[3:0];
    case (state_reg)
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = init_idx_reg;
        wr_data = 32'd0;
        wr_be   = 4'hF;
      end
      BEAT2: begin
        wr_en   = is_store_reg;
        wr_idx  = hi_idx_reg;
        wr_data = hi_data_reg;
        wr_be   = hi_be_reg;
      end
      default: wr_en = accept & store & ~acc_fault;
    endcase
    if (!rst_n) wr_en = 1'b0;
  end

  assign rd_idx = beat2 ? hi_idx_reg : acc_idx;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) lane_mem[wr_idx] <= wr_data[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
    end
  endgenerate

  logic [63:0] ld_pair;
  logic [1:0]  ld_off;
  logic [2:0]  ld_type;
  logic [31:0] ld_raw, ld_ext;

  assign ld_pair = beat2 ? {rd_word, lo_word_reg} : {32'd0, rd_word};
  assign ld_off  = beat2 ? byte_off_reg : byte_off;
  assign ld_type = beat2 ? type_reg : Type;
  assign ld_raw  = 32'(ld_pair >> {ld_off, 3'b000});

  always_comb begin
    case (ld_type)
      3'd0:    ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'd1:    ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'd3:    ld_ext = {24'd0, ld_raw[7:0]};
      3'd4:    ld_ext = {16'd0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= INIT_CLEAR ? INIT : IDLE;
      init_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == INIT) init_idx_reg <= init_idx_reg + AW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = rst_n && (state_reg == IDLE);
    case (state_reg)
      INIT:    if (init_idx_reg == AW'(DEPTH_WORDS - 1)) state_next = IDLE;
      IDLE:    if (accept && !acc_fault && misaligned) state_next = BEAT2;
      BEAT2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Access context captured at acceptance for the second beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_reg <= store;
      type_reg     <= Type;
      byte_off_reg <= byte_off;
      hi_idx_reg   <= acc_idx + AW'(1);
      hi_data_reg  <= data_wide[63:32];
      hi_be_reg    <= be_wide[7:4];
      lo_word_reg  <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      load_data_reg <= 32'd0;
    end else begin
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      if (accept) begin
        if (acc_fault) begin
          done_reg      <= 1'b1;
          fault_reg     <= 1'b1;
          load_data_reg <= 32'd0;
        end else if (!misaligned) begin
          done_reg <= 1'b1;
          if (!store) load_data_reg <= ld_ext;
        end
      end else if (beat2) begin
        done_reg <= 1'b1;
        if (!is_store_reg) load_data_reg <= ld_ext;
      end
    end
  end

  assign done      = done_reg;
  assign fault     = fault_reg;
  assign load_data = load_data_reg;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver queues expected completions,
// a negedge monitor pops and checks them whenever done is seen.
module tb_data_mem_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [31:0] direccion = '0;
  logic [31:0] offset = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  Type = '0;
  logic        ready, done, fault;
  logic [31:0] load_data;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .store(store),
    .direccion(direccion), .offset(offset), .store_data(store_data), .Type(Type),
    .ready(ready), .done(done), .fault(fault), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          flt;
    bit          is_ld;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pcyc = 0;
  logic [31:0] exp_ld = '0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Monitor: load_data must hold across stores, so it tracks the last expected load result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) exp_ld = '0;
    checks++;
    if (!done && fault) begin
      errors++;
      $display("FAIL fault_without_done cycle %0d: fault=%b done=%b", pcyc, fault, done);
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done cycle %0d: done=1 with nothing pending", pcyc);
      end else begin
        e = sb.pop_front();
        if (e.flt || e.is_ld) exp_ld = e.data;
        checks++;
        if (pcyc != e.due) begin
          errors++;
          $display("FAIL %s latency: done at cycle %0d, expected %0d", e.name, pcyc, e.due);
        end
        checks++;
        if (fault !== e.flt) begin
          errors++;
          $display("FAIL %s fault: got %b expected %b", e.name, fault, e.flt);
        end
        checks++;
        if (load_data !== exp_ld) begin
          errors++;
          $display("FAIL %s load_data: got %08h expected %08h", e.name, load_data, exp_ld);
        end
        $display("TXN %-12s cycle=%0d fault=%b load_data=%08h", e.name, pcyc, fault, load_data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with req still high.
  task automatic issue(input string nm, input bit st, input logic [31:0] dir, input logic [31:0] off,
                       input logic [31:0] sd, input logic [2:0] ty, input int lat, input bit flt,
                       input logic [31:0] exp, input bit push);
    int n = 0;
    store = st; direccion = dir; offset = off; store_data = sd; Type = ty; req = 1'b1;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL %s ready_timeout: ready=%b after %0d cycles, expected 1", nm, ready, n);
      req = 1'b0;
      return;
    end
    if (push) sb.push_back('{due: pcyc + lat, flt: flt, is_ld: !st, data: (flt ? 32'd0 : exp), name: nm});
    @(negedge clk);
  endtask

  task automatic ld(input string nm, input logic [31:0] dir, input logic [31:0] off,
                    input logic [2:0] ty, input int lat, input logic [31:0] exp);
    issue(nm, 1'b0, dir, off, 32'd0, ty, lat, 1'b0, exp, 1'b1);
  endtask

  task automatic st(input string nm, input logic [31:0] dir, input logic [31:0] off,
                    input logic [31:0] sd, input logic [2:0] ty, input int lat);
    issue(nm, 1'b1, dir, off, sd, ty, lat, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic bad(input string nm, input bit is_st, input logic [31:0] dir, input logic [31:0] off,
                     input logic [2:0] ty);
    issue(nm, is_st, dir, off, 32'hFFFF_FFFF, ty, 1, 1'b1, 32'd0, 1'b1);
  endtask

  task automatic do_reset(input string nm);
    req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || load_data !== 32'd0) begin
      errors++;
      $display("FAIL %s reset_outputs: ready=%b done=%b fault=%b load_data=%08h, expected all 0",
               nm, ready, done, fault, load_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL %s init_ready[%0d]: got %b expected 0", nm, i, ready);
      end
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after_init: got %b expected 1", nm, ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst1");
    for (int i = 0; i < DEPTH; i++) ld($sformatf("lw_init%0d", i), 32'(4 * i), 0, 3'd2, 1, 32'd0);

    st("sw_mis6", 4, 2, 32'hAABB_CCDD, 3'd2, 2);
    ld("lw4", 0, 4, 3'd2, 1, 32'hCCDD_0000);
    ld("lw8", 8, 0, 3'd2, 1, 32'h0000_AABB);
    ld("lw_mis6", 6, 0, 3'd2, 2, 32'hAABB_CCDD);

    st("sw8", 8, 0, 32'h80FF_7F01, 3'd2, 1);
    ld("lb9", 9, 0, 3'd0, 1, 32'h0000_007F);
    ld("lbu9", 9, 0, 3'd3, 1, 32'h0000_007F);
    ld("lh9", 9, 0, 3'd1, 1, 32'hFFFF_FF7F);
    ld("lhu9", 9, 0, 3'd4, 1, 32'h0000_FF7F);
    ld("lb11", 11, 0, 3'd0, 1, 32'hFFFF_FF80);
    ld("lh_mis11", 11, 0, 3'd1, 2, 32'h0000_0080);
    ld("lw_mis7", 7, 0, 3'd2, 2, 32'hFF7F_01CC);

    st("sh_mis15", 15, 0, 32'h0000_1234, 3'd1, 2);
    ld("lw12", 12, 0, 3'd2, 1, 32'h3400_0000);
    ld("lw16", 16, 0, 3'd2, 1, 32'h0000_0012);
    st("sb13", 13, 0, 32'hDEAD_BEA5, 3'd0, 1);
    ld("lw12b", 12, 0, 3'd2, 1, 32'h3400_A500);

    st("sw60", 60, 0, 32'h1234_5678, 3'd2, 1);
    bad("sw62_oob", 1'b1, 60, 2, 3'd2);
    bad("lw62_oob", 1'b0, 60, 2, 3'd2);
    ld("lw60", 60, 0, 3'd2, 1, 32'h1234_5678);
    ld("lb63", 63, 0, 3'd0, 1, 32'h0000_0012);
    bad("lb64_oob", 1'b0, 64, 0, 3'd0);
    bad("ld_ty5", 1'b0, 0, 0, 3'd5);
    bad("st_ty3", 1'b1, 0, 0, 3'd3);
    ld("lw0", 0, 0, 3'd2, 1, 32'd0);
    ld("lw_wrap", 32'hFFFF_FFFC, 8, 3'd2, 1, 32'hCCDD_0000);
    bad("lw_high", 1'b0, 32'hFFFF_FFF0, 0, 3'd2);

    for (int i = 0; i < 4; i++) st($sformatf("b2b_sw%0d", i), 32'(20 + 4 * i), 0, {4{8'(8'h11 * (i + 1))}}, 3'd2, 1);
    for (int i = 0; i < 4; i++) ld($sformatf("b2b_lw%0d", i), 32'(20 + 4 * i), 0, 3'd2, 1, {4{8'(8'h11 * (i + 1))}});

    issue("sw_abort", 1'b1, 6, 0, 32'h5566_7788, 3'd2, 2, 1'b0, 32'd0, 1'b0);
    req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %b expected 0", done);
    end
    do_reset("rst2");
    for (int i = 0; i < DEPTH; i++) ld($sformatf("lw_clr%0d", i), 32'(4 * i), 0, 3'd2, 1, 32'd0);

    req = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d completions still pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
